serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer that runs one 1-bit full-add cell serially to add or subtract two WIDTH-bit operands, LSB first, one bit per clock.
- Provides a start/busy/done handshake, operand capture, carry sequencing, and registered result, carry-out and signed-overflow outputs.
- Sits between a requester (bench or control FSM) and the bit-level adder datapath. It replaces a WIDTH-bit ripple adder where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- sub  input  1  0 = a_in+b_in+cin; 1 = a_in-b_in (cin ignored); captured with start.
- a_in  input  WIDTH  operand A; captured with start.
- b_in  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  last completed result.
- cout  output  1  carry-out of last result; for sub, 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow of last result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry and counter are cleared.
  - Reset takes effect immediately, including mid-operation: the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge E is the accept. On accept:
    - Ar <= a_in.
    - Br <= sub ? ~b_in : b_in.
    - carry <= sub ? 1 : cin.
    - cnt <= 0.
    - state <= RUN.
- RUN:
  - busy=1; start is ignored.
  - Each edge:
    - s = Ar[0]^Br[0]^carry.
    - c = majority(Ar[0], Br[0], carry).
    - Sr shifts right with s entering at the MSB.
    - Ar and Br shift right.
    - carry <= c.
    - cnt <= cnt+1.
  - At the MSB step (cnt==WIDTH-1):
    - Retain the carry into the MSB (the carry value before that step).
    - sum <= final Sr, including this step's s.
    - cout <= c.
    - ovf <= c ^ carry_into_MSB.
    - done <= 1.
    - state <= DONE.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - Next edge: done <= 0 and state <= IDLE.
  - Exception: if start=1 in this cycle, it is accepted exactly as in IDLE and state <= RUN (back-to-back operation).
- Latency:
  - Accept at edge E; bits are processed at edges E+1..E+WIDTH.
  - done is high during the cycle following edge E+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- Output hold: sum, cout and ovf change only at the completion edge and hold their value otherwise, including throughout the next RUN.
- Operand stability: a_in, b_in, sub and cin are sampled only at the accept edge; changes during RUN have no effect.
- start held high continuously:
  - Accepted in IDLE or DONE only.
  - Produces back-to-back operations, one per WIDTH+1 cycles.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - cnt wraps only via reset to 0 on accept; it never counts past WIDTH-1.
- No illegal-state lockup: any unused state encoding returns to IDLE on the next edge with done=0.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Required: busy, done, sum, cout and ovf go 0 before the next edge and stay 0 while rst_n=0.
- Add with signed overflow (WIDTH=8):
  - Stimulus: a=0x5A, b=0x33, cin=0, sub=0; start pulse at edge E.
  - Required: done high only in the cycle after E+8; sum=0x8D, cout=0, ovf=1; busy=1 for exactly 8 cycles.
- Carry chain:
  - Stimulus: 0xFF+0x01 with cin=0; then 0xFF+0x00 with cin=1.
  - Required: both give sum=0x00, cout=1, ovf=0.
- Subtract:
  - Stimulus: 0x10-0x20; then 0x80-0x01.
  - Required: first gives sum=0xF0, cout=0, ovf=0; second gives sum=0x7F, cout=1, ovf=1.
- Handshake:
  - Stimulus: hold start=1 through the whole operation, changing a_in/b_in every cycle during RUN.
  - Required: the result matches the operands captured at accept; the second op is accepted in the DONE cycle; its done arrives 9 cycles after the first done.
- Reset mid-operation:
  - Stimulus: drop rst_n after 4 RUN edges, then release it; then 0x01+0x02.
  - Required: no done for the aborted op; sum holds 0 after reset; the next op gives sum=0x03, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-add step per clock, LSB first, with start/busy/done handshake.
// Latency: accept edge + WIDTH processing edges, done for one cycle; start is ignored while busy (back-to-back from DONE).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] s_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        s_shift = {bit_s, s_q[WIDTH-1:1]};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, so cout=1 means no borrow.
                    a_d     = a_in;
                    b_d     = sub ? ~b_in : b_in;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d     = s_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = s_shift;
                    cout_d  = bit_c;
                    ovf_d   = bit_c ^ carry_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                          input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int  busy_cnt;
        bit  seen;
        busy_cnt = 0;
        seen     = 0;
        @(negedge clk);
        a_in = a; b_in = b; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  done_cyc1;
        int  done_cyc2;
        bit  seen;
        bit  any_done;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "add_ovf");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "carry_b1");
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "carry_cin");
        run_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

        // start held high; operands scrambled during RUN, second pair presented in DONE.
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        seen = 0; done_cyc1 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1; done_cyc1 = cyc;
            end else begin
                a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                @(negedge clk);
            end
        end
        check("hs1_done_seen", 32'(seen), 32'd1);
        check("hs1_sum",  32'(sum),  32'h47);
        check("hs1_cout", 32'(cout), 32'd0);
        check("hs1_ovf",  32'(ovf),  32'd0);
        a_in = 8'h70; b_in = 8'h10; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        check("hs2_accept_busy", 32'(busy), 32'd1);
        check("hs_sum_hold", 32'(sum), 32'h47);
        seen = 0; done_cyc2 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1; done_cyc2 = cyc;
            end else begin
                a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("hs2_done_seen", 32'(seen), 32'd1);
        check("hs2_spacing", done_cyc2 - done_cyc1, 9);
        check("hs2_sum",  32'(sum),  32'h80);
        check("hs2_cout", 32'(cout), 32'd0);
        check("hs2_ovf",  32'(ovf),  32'd1);
        @(negedge clk);
        check("hs_idle_after", 32'(busy | done), 32'd0);

        // Abort after 4 RUN edges with an asynchronous mid-cycle reset.
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum",  32'(sum),  32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf",  32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        check("arst_hold", 32'({busy, done, sum, cout, ovf}), 32'd0);
        rst_n = 1'b1;
        any_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) any_done = 1;
        end
        check("arst_no_done", 32'(any_done), 32'd0);
        check("arst_sum_after", 32'(sum), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
